// File: rtl/key_search_sequencer_if.sv
// key_search_sequencer_if: control, key-range, compare-engine and result signals of the key search sequencer
// slave  : sequencer side (start/abort/key_lo/key_hi/eng_match in; eng_*/busy/done/found/exhausted/found_key/keys_tried/cycles_run out)
// master : controller/engine side, directions mirrored
interface key_search_sequencer_if #(parameter int KEY_W = 24);
  logic start, abort, eng_valid, eng_match, busy, done, found, exhausted;
  logic [KEY_W-1:0] key_lo, key_hi, eng_key, found_key;
  logic [KEY_W:0] keys_tried;
  logic [31:0] cycles_run;
  modport slave(
    input start, abort, key_lo, key_hi, eng_match,
    output eng_valid, eng_key, busy, done, found, exhausted, found_key, keys_tried, cycles_run
  );
  modport master(
    output start, abort, key_lo, key_hi, eng_match,
    input eng_valid, eng_key, busy, done, found, exhausted, found_key, keys_tried, cycles_run
  );
endinterface

// File: rtl/key_search_sequencer.sv
// key_search_sequencer: issues keys key_lo..key_hi to a fixed-latency compare engine, stops on first match or range end
// Ports: clk, reset (async, active-high), bus (key_search_sequencer_if.slave: start/abort/range in,
//   eng_valid/eng_key out, eng_match in, busy/done/found/exhausted/found_key/keys_tried/cycles_run out)
// Optional: define KSEQ_PERF_EN for a saturating RUN+DRAIN cycle counter on cycles_run (tied to 0 otherwise)
module key_search_sequencer #(
  parameter int KEY_W = 24,
  parameter int ENG_LAT = 3
) (
  input logic clk,
  input logic reset,
  key_search_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [KEY_W-1:0] ONE_K = 1;
  localparam logic [KEY_W:0] ONE_T = 1;
  state_t state, nxt;
  logic [KEY_W-1:0] cur, hi, fkey;
  logic [KEY_W-1:0] pk [ENG_LAT];
  logic [ENG_LAT-1:0] pv;
  logic [KEY_W:0] tried;
  logic fnd, exh, done_q, active, launch, hit, flush;
  logic [31:0] cyc;
  always_comb begin
    active = state == RUN || state == DRAIN;
    launch = state == IDLE && bus.start;
    hit = active && pv[ENG_LAT-1] && bus.eng_match;
  end
  // abort outranks a match, a match outranks the move to DRAIN
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = !bus.start ? IDLE : (bus.key_lo <= bus.key_hi) ? RUN : DONE;
      RUN: nxt = bus.abort ? IDLE : hit ? DONE : (cur == hi) ? DRAIN : RUN;
      DRAIN: nxt = bus.abort ? IDLE : (hit || pv == '0) ? DONE : DRAIN;
      DONE: nxt = bus.start ? DONE : IDLE;
      default: nxt = IDLE;
    endcase
  end
  // leaving the search discards every in-flight key
  assign flush = nxt == IDLE || nxt == DONE;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= '0;
      hi <= '0;
      fkey <= '0;
      tried <= '0;
      fnd <= 1'b0;
      exh <= 1'b0;
      done_q <= 1'b0;
      pv <= '0;
      for (int i = 0; i < ENG_LAT; i++) pk[i] <= '0;
    end else begin
      done_q <= nxt == DONE && state != DONE;
      pv <= flush ? '0 : (pv << 1) | ENG_LAT'(state == RUN);
      pk[0] <= cur;
      for (int i = 1; i < ENG_LAT; i++) pk[i] <= pk[i-1];
      if (launch) begin
        cur <= bus.key_lo;
        hi <= bus.key_hi;
        tried <= '0;
        fnd <= 1'b0;
        fkey <= '0;
        exh <= bus.key_lo > bus.key_hi;
      end else begin
        if (state == RUN) begin
          tried <= tried + ONE_T;
          if (cur != hi) cur <= cur + ONE_K;
        end
        if (hit && !bus.abort) begin
          fnd <= 1'b1;
          fkey <= pk[ENG_LAT-1];
        end
        if (state == DRAIN && nxt == DONE && !hit) exh <= 1'b1;
      end
    end
  end
`ifdef KSEQ_PERF_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) cyc <= '0;
    else if (launch) cyc <= '0;
    else if (active && cyc != '1) cyc <= cyc + 32'd1;
`else
  assign cyc = '0;
`endif
  always_comb begin
    bus.eng_valid = state == RUN;
    bus.eng_key = state == RUN ? cur : '0;
    bus.busy = active;
    bus.done = done_q;
    bus.found = fnd;
    bus.exhausted = exh;
    bus.found_key = fkey;
    bus.keys_tried = tried;
    bus.cycles_run = cyc;
  end
endmodule
